fetch_decode_queue: RTL and testbench

- Dual-issue instruction queue between the two-lane fetch stage and decode.
- Accepts 0–2 {PC, instruction} pairs per cycle from fetch lanes 1/2; presents the 2 oldest entries in program order to decode; decode consumes 0–2 per cycle.
- Decouples decode stalls from fetch. Produces per-lane fetch hold signals with the same polarity as the fetch PC-register enables (1 = hold PC).
- Flushes on a redirect (jump/branch).

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fq_storage.sv | 50 +++++
 rtl/fetch_decode_queue.sv | 118 +++++++++++
 tb/tb_fetch_decode_queue.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: definitions shared by the fetch/decode instruction queue.
//   fetch_entry_t  - one queued fetch word {pc, instr}
//   RESET_PC       - first PC fetched after reset
//   PC_STRIDE_*    - PC distance between fetch pairs and between the two lanes
//   QUEUE_DEPTH    - default queue depth
//   clip_take()    - maps a decode take request onto the 0..2 range
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] RESET_PC       = 32'h0040_0000;
  localparam logic [31:0] PC_STRIDE_PAIR = 32'd8;
  localparam logic [31:0] PC_STRIDE_LANE = 32'd4;
  localparam int          QUEUE_DEPTH    = 8;

  // Decode can consume at most two entries per cycle; a request of 3 is
  // treated as 2.
  function automatic logic [1:0] clip_take(input logic [1:0] take);
    return (take == 2'd3) ? 2'd2 : take;
  endfunction

endpackage

// File: rtl/fq_storage.sv
// fq_storage: DEPTH-entry {pc, instr} register array for the fetch queue.
//   i_clk                         rising-edge clock
//   i_we1/i_waddr1/i_wpc1/i_winstr1  write port 1
//   i_we2/i_waddr2/i_wpc2/i_winstr2  write port 2 (wins on an index collision)
//   i_raddr1/o_rpc1/o_rinstr1     asynchronous read port 1
//   i_raddr2/o_rpc2/o_rinstr2     asynchronous read port 2
// Contents are not reset; validity is tracked by the queue occupancy.
module fq_storage #(
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_we1,
  input  logic [PTR_W-1:0]  i_waddr1,
  input  logic [DATA_W-1:0] i_wpc1,
  input  logic [DATA_W-1:0] i_winstr1,
  input  logic              i_we2,
  input  logic [PTR_W-1:0]  i_waddr2,
  input  logic [DATA_W-1:0] i_wpc2,
  input  logic [DATA_W-1:0] i_winstr2,
  input  logic [PTR_W-1:0]  i_raddr1,
  output logic [DATA_W-1:0] o_rpc1,
  output logic [DATA_W-1:0] o_rinstr1,
  input  logic [PTR_W-1:0]  i_raddr2,
  output logic [DATA_W-1:0] o_rpc2,
  output logic [DATA_W-1:0] o_rinstr2
);

  logic [DATA_W-1:0] r_pc    [DEPTH];
  logic [DATA_W-1:0] r_instr [DEPTH];

  // Port 2 is written last so it takes the slot if both ports hit one index.
  always_ff @(posedge i_clk) begin
    if (i_we1) begin
      r_pc[i_waddr1]    <= i_wpc1;
      r_instr[i_waddr1] <= i_winstr1;
    end
    if (i_we2) begin
      r_pc[i_waddr2]    <= i_wpc2;
      r_instr[i_waddr2] <= i_winstr2;
    end
  end

  assign o_rpc1    = r_pc[i_raddr1];
  assign o_rinstr1 = r_instr[i_raddr1];
  assign o_rpc2    = r_pc[i_raddr2];
  assign o_rinstr2 = r_instr[i_raddr2];

endmodule

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: dual-issue instruction queue between fetch and decode.
//   clk, rst                  clock, synchronous active-high reset
//   flush                     redirect: drop all queued and incoming words
//   in_valid/pc/instr_1,_2    fetch lanes (lane 1 older)
//   fetch_hold_1,_2           1 = fetch must hold its PC (both lanes together)
//   out_valid/pc/instr_1,_2   two oldest entries, program order
//   out_take                  entries consumed by decode this cycle (0..2)
//   count                     current occupancy 0..DEPTH
module fetch_decode_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH  = QUEUE_DEPTH,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid_1,
  input  logic [DATA_W-1:0] in_pc_1,
  input  logic [DATA_W-1:0] in_instr_1,
  input  logic              in_valid_2,
  input  logic [DATA_W-1:0] in_pc_2,
  input  logic [DATA_W-1:0] in_instr_2,
  output logic              fetch_hold_1,
  output logic              fetch_hold_2,
  output logic              out_valid_1,
  output logic [DATA_W-1:0] out_pc_1,
  output logic [DATA_W-1:0] out_instr_1,
  output logic              out_valid_2,
  output logic [DATA_W-1:0] out_pc_2,
  output logic [DATA_W-1:0] out_instr_2,
  input  logic [1:0]        out_take,
  output logic [PTR_W:0]    count
);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;

  logic              w_has_room;
  logic              w_enq;
  logic [1:0]        w_n_in;
  logic [1:0]        w_take;
  logic [1:0]        w_n_out;
  logic              w_we1;
  logic              w_we2;
  logic [DATA_W-1:0] w_wpc1;
  logic [DATA_W-1:0] w_winstr1;
  logic [DATA_W-1:0] w_rpc1;
  logic [DATA_W-1:0] w_rinstr1;
  logic [DATA_W-1:0] w_rpc2;
  logic [DATA_W-1:0] w_rinstr2;

  // Room for a whole pair, judged on registered occupancy only so the hold
  // never depends on what decode does this cycle.
  assign w_has_room = (r_count <= (PTR_W+1)'(DEPTH - 2));
  assign w_enq      = w_has_room & ~flush;
  assign w_n_in     = w_enq ? ({1'b0, in_valid_1} + {1'b0, in_valid_2}) : 2'd0;

  // Dequeue never exceeds occupancy; when the clip applies count is below 2.
  assign w_take  = clip_take(out_take);
  assign w_n_out = ((PTR_W+1)'(w_take) > r_count) ? r_count[1:0] : w_take;

  // A lone word always lands at wr_ptr, whichever lane carried it.
  assign w_we1     = w_enq & (in_valid_1 | in_valid_2);
  assign w_we2     = w_enq & in_valid_1 & in_valid_2;
  assign w_wpc1    = in_valid_1 ? in_pc_1    : in_pc_2;
  assign w_winstr1 = in_valid_1 ? in_instr_1 : in_instr_2;

  fq_storage #(
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W),
    .DATA_W (DATA_W)
  ) u_storage (
    .i_clk     (clk),
    .i_we1     (w_we1),
    .i_waddr1  (r_wr_ptr),
    .i_wpc1    (w_wpc1),
    .i_winstr1 (w_winstr1),
    .i_we2     (w_we2),
    .i_waddr2  (r_wr_ptr + PTR_W'(1)),
    .i_wpc2    (in_pc_2),
    .i_winstr2 (in_instr_2),
    .i_raddr1  (r_rd_ptr),
    .o_rpc1    (w_rpc1),
    .o_rinstr1 (w_rinstr1),
    .i_raddr2  (r_rd_ptr + PTR_W'(1)),
    .o_rpc2    (w_rpc2),
    .o_rinstr2 (w_rinstr2)
  );

  // Control state: pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_in);
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_n_out);
      r_count  <= r_count + (PTR_W+1)'(w_n_in) - (PTR_W+1)'(w_n_out);
    end
  end

  assign fetch_hold_1 = ~w_has_room | rst;
  assign fetch_hold_2 = ~w_has_room | rst;

  assign out_valid_1 = (r_count >= (PTR_W+1)'(1));
  assign out_valid_2 = (r_count >= (PTR_W+1)'(2));
  assign out_pc_1    = out_valid_1 ? w_rpc1    : '0;
  assign out_instr_1 = out_valid_1 ? w_rinstr1 : '0;
  assign out_pc_2    = out_valid_2 ? w_rpc2    : '0;
  assign out_instr_2 = out_valid_2 ? w_rinstr2 : '0;

  assign count = r_count;

endmodule

// File: tb/tb_fetch_decode_queue.sv
module tb_fetch_decode_queue;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        in_valid_1, in_valid_2;
  logic [31:0] in_pc_1, in_instr_1, in_pc_2, in_instr_2;
  logic        fetch_hold_1, fetch_hold_2;
  logic        out_valid_1, out_valid_2;
  logic [31:0] out_pc_1, out_instr_1, out_pc_2, out_instr_2;
  logic [1:0]  out_take;
  logic [3:0]  count;

  int n_err = 0;
  int n_chk = 0;
  int n_illegal = 0;

  always #5 clk = ~clk;

  fetch_decode_queue #(.DEPTH(8), .PTR_W(3), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid_1   (in_valid_1),
    .in_pc_1      (in_pc_1),
    .in_instr_1   (in_instr_1),
    .in_valid_2   (in_valid_2),
    .in_pc_2      (in_pc_2),
    .in_instr_2   (in_instr_2),
    .fetch_hold_1 (fetch_hold_1),
    .fetch_hold_2 (fetch_hold_2),
    .out_valid_1  (out_valid_1),
    .out_pc_1     (out_pc_1),
    .out_instr_1  (out_instr_1),
    .out_valid_2  (out_valid_2),
    .out_pc_2     (out_pc_2),
    .out_instr_2  (out_instr_2),
    .out_take     (out_take),
    .count        (count)
  );

  // Protocol monitor: decode must never ask for more than is queued.
  always @(negedge clk) begin
    if (rst === 1'b0 && ({2'b00, out_take} > count)) begin
      n_illegal++;
      $display("note: out_take=%0d exceeds count=%0d", out_take, count);
    end
  end

  typedef struct {
    logic        fl;
    logic        v1;
    logic [31:0] p1, i1;
    logic        v2;
    logic [31:0] p2, i2;
    logic [1:0]  take;
    logic [3:0]  e_cnt;
    logic        e_v1, e_v2;
    logic [31:0] e_p1, e_i1, e_p2, e_i2;
    logic        e_hold;
  } vec_t;

  vec_t tbl[$];

  // Word n of the program: PC advances one lane stride per word.
  function automatic logic [31:0] pcn(input int n);
    return RESET_PC + 32'(n / 2) * PC_STRIDE_PAIR + 32'(n % 2) * PC_STRIDE_LANE;
  endfunction

  function automatic logic [31:0] insn(input int n);
    if (n == 0) return 32'h2008_0001;
    if (n == 1) return 32'h2009_0002;
    return 32'h1000_0000 + 32'(n);
  endfunction

  // n1/n2 < 0 means lane idle; h1/h2 < 0 means that output slot is empty.
  function automatic void add(input int fl, input int n1, input int n2, input int take,
                              input int ecnt, input int h1, input int h2, input int ehold);
    vec_t v;
    v.fl     = (fl != 0);
    v.v1     = (n1 >= 0);
    v.p1     = (n1 >= 0) ? pcn(n1) : 32'h0;
    v.i1     = (n1 >= 0) ? insn(n1) : 32'h0;
    v.v2     = (n2 >= 0);
    v.p2     = (n2 >= 0) ? pcn(n2) : 32'h0;
    v.i2     = (n2 >= 0) ? insn(n2) : 32'h0;
    v.take   = 2'(take);
    v.e_cnt  = 4'(ecnt);
    v.e_v1   = (h1 >= 0);
    v.e_v2   = (h2 >= 0);
    v.e_p1   = (h1 >= 0) ? pcn(h1) : 32'h0;
    v.e_i1   = (h1 >= 0) ? insn(h1) : 32'h0;
    v.e_p2   = (h2 >= 0) ? pcn(h2) : 32'h0;
    v.e_i2   = (h2 >= 0) ? insn(h2) : 32'h0;
    v.e_hold = (ehold != 0);
    tbl.push_back(v);
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic idle_inputs();
    flush = 1'b0; in_valid_1 = 1'b0; in_valid_2 = 1'b0;
    in_pc_1 = '0; in_instr_1 = '0; in_pc_2 = '0; in_instr_2 = '0;
    out_take = 2'd0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    //   fl  n1  n2 take cnt  h1  h2 hold
    add(0,   0,  1, 0,   2,   0,  1, 0);  // first pair visible next cycle
    add(0,   2,  3, 0,   4,   0,  1, 0);
    add(0,   4,  5, 0,   6,   0,  1, 0);
    add(0,   6,  7, 0,   8,   0,  1, 1);  // full, hold
    add(0,   8,  9, 0,   8,   0,  1, 1);  // pair while held: ignored
    add(0,  -1, -1, 2,   6,   2,  3, 0);
    add(0,   8,  9, 2,   6,   4,  5, 0);  // enqueue + dequeue at 6
    add(0,  -1, -1, 1,   5,   5,  6, 0);
    add(1,  20, 21, 2,   0,  -1, -1, 0);  // flush at count 5
    add(0,   0,  1, 0,   2,   0,  1, 0);
    add(0,   2,  3, 0,   4,   0,  1, 0);
    add(0,   4,  5, 0,   6,   0,  1, 0);
    add(0,   6, -1, 0,   7,   0,  1, 1);  // single word -> 7, wr_ptr=7
    add(0,   7,  8, 2,   5,   2,  3, 0);  // held: pair dropped, dequeue still works
    add(0,   7,  8, 0,   7,   2,  3, 1);  // lane 2 wraps to index 0
    add(0,  -1, -1, 2,   5,   4,  5, 0);
    add(0,  -1, -1, 2,   3,   6,  7, 0);
    add(0,  -1, -1, 2,   1,   8, -1, 0);  // read wrap: P8 from index 0
    add(0,  -1, -1, 1,   0,  -1, -1, 0);
    add(0,   9, 10, 0,   2,   9, 10, 0);
    add(0,  11, 12, 0,   4,   9, 10, 0);
    add(0,  -1, -1, 3,   2,  11, 12, 0);  // take=3 acts as 2
    add(0,  -1, -1, 2,   0,  -1, -1, 0);
    add(0,  -1, 65, 0,   1,  65, -1, 0);  // lane-2-only word goes to head
    add(0,  -1, -1, 2,   0,  -1, -1, 0);  // illegal take clipped to count

    // Reset state: holds forced while rst is high, queue empty.
    @(posedge clk); #1;
    chk("rst_hold1", 32'(fetch_hold_1), 32'd1);
    chk("rst_hold2", 32'(fetch_hold_2), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_v1", 32'(out_valid_1), 32'd0);
    chk("rst_v2", 32'(out_valid_2), 32'd0);
    chk("rst_pc1", out_pc_1, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_hold1", 32'(fetch_hold_1), 32'd0);
    chk("post_rst_hold2", 32'(fetch_hold_2), 32'd0);

    for (int k = 0; k < tbl.size(); k++) begin
      flush      = tbl[k].fl;
      in_valid_1 = tbl[k].v1;
      in_pc_1    = tbl[k].p1;
      in_instr_1 = tbl[k].i1;
      in_valid_2 = tbl[k].v2;
      in_pc_2    = tbl[k].p2;
      in_instr_2 = tbl[k].i2;
      out_take   = tbl[k].take;
      @(posedge clk); #1;
      idle_inputs();
      chk($sformatf("v%0d_count", k), 32'(count), 32'(tbl[k].e_cnt));
      chk($sformatf("v%0d_valid1", k), 32'(out_valid_1), 32'(tbl[k].e_v1));
      chk($sformatf("v%0d_valid2", k), 32'(out_valid_2), 32'(tbl[k].e_v2));
      chk($sformatf("v%0d_pc1", k), out_pc_1, tbl[k].e_p1);
      chk($sformatf("v%0d_instr1", k), out_instr_1, tbl[k].e_i1);
      chk($sformatf("v%0d_pc2", k), out_pc_2, tbl[k].e_p2);
      chk($sformatf("v%0d_instr2", k), out_instr_2, tbl[k].e_i2);
      chk($sformatf("v%0d_hold1", k), 32'(fetch_hold_1), 32'(tbl[k].e_hold));
      chk($sformatf("v%0d_hold2", k), 32'(fetch_hold_2), 32'(tbl[k].e_hold));
    end

    // Exactly the one deliberate over-take in the last vector was seen.
    chk("illegal_take_seen", 32'(n_illegal), 32'd1);

    // Mid-run reset drops contents and wins over same-cycle enqueue.
    in_valid_1 = 1'b1; in_pc_1 = pcn(30); in_instr_1 = insn(30);
    in_valid_2 = 1'b1; in_pc_2 = pcn(31); in_instr_2 = insn(31);
    @(posedge clk); #1;
    chk("pre_rst_count", 32'(count), 32'd2);
    chk("pre_rst_pc2", out_pc_2, pcn(31));
    rst = 1'b1;
    in_pc_1 = pcn(32); in_instr_1 = insn(32);
    in_pc_2 = pcn(33); in_instr_2 = insn(33);
    @(posedge clk); #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_hold1", 32'(fetch_hold_1), 32'd1);
    chk("midrst_v1", 32'(out_valid_1), 32'd0);
    rst = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    chk("after_midrst_count", 32'(count), 32'd0);
    chk("after_midrst_hold2", 32'(fetch_hold_2), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
